// File: rtl/add_seq_ctrl.sv
// add_seq_ctrl: N-bit add/subtract built from one W-bit ripple adder that is
// reused over N/W cycles, least-significant chunk first. A registered carry
// links the chunks. The result is shifted into s from the top, so after the
// last chunk s holds the full sum and co holds bit N of that sum.
//
// Handshake: a request is accepted on a rising edge where start=1 and
// ready=1. ready is high only in IDLE. done is a one-cycle pulse in FIN.
// s/co are valid from done and held until the next accept.
module add_seq_ctrl #(
  parameter int N = 64,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic         ready,
  input  logic         op_sub,
  input  logic         ci,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] s,
  output logic         co,
  output logic         done,
  output logic [1:0]   dbg_state
);

  localparam int NCH = N / W;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [N-1:0]   r_a;
  logic [N-1:0]   r_b;
  logic [N-1:0]   r_s;
  logic           r_carry;
  logic           r_co;
  logic [CW-1:0]  r_cnt;
  logic [W-1:0]   w_sum;
  logic [W:0]     w_c;
  logic [N-1:0]   w_sum_top;
  logic           w_last;
  logic           w_accept;

  // Shared W-bit ripple adder: operands are always the low chunk of the
  // shifting operand registers, carry-in is the registered chunk carry.
  assign w_c[0] = r_carry;
  for (genvar gi = 0; gi < W; gi++) begin : g_ripple
    assign w_sum[gi]  = r_a[gi] ^ r_b[gi] ^ w_c[gi];
    assign w_c[gi+1]  = (r_a[gi] & r_b[gi]) | (w_c[gi] & (r_a[gi] ^ r_b[gi]));
  end

  // Chunk sum placed at the top of an N-bit word; also correct when W==N.
  assign w_sum_top = N'(w_sum) << (N - W);
  assign w_last    = (r_cnt == CW'(NCH - 1));

  assign s         = r_s;
  assign co        = r_co;
  assign dbg_state = r_state;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and handshake outputs; start outside IDLE is simply ignored.
  always_comb begin
    w_state_nxt = r_state;
    ready       = 1'b0;
    done        = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        ready = 1'b1;
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_last) begin
          w_state_nxt = ST_FIN;
        end
      end
      ST_FIN: begin
        done        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Datapath: latch operands on accept, then consume one chunk per RUN cycle.
  // Subtraction is A + ~B + 1, so B is inverted at accept and carry starts at 1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_s     <= '0;
      r_carry <= 1'b0;
      r_co    <= 1'b0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= op_sub ? ~b : b;
      r_carry <= op_sub | ci;
      r_cnt   <= '0;
    end else if (r_state == ST_RUN) begin
      r_a     <= r_a >> W;
      r_b     <= r_b >> W;
      r_s     <= (r_s >> W) | w_sum_top;
      r_carry <= w_c[W];
      if (w_last) begin
        r_co  <= w_c[W];
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_add_seq_ctrl.sv
// tb_add_seq_ctrl: three add_seq_ctrl instances (N=64 with W=8, 16, 64).
// A per-instance reference model tracks busy/idle from start alone and
// computes the expected sum with plain 65-bit arithmetic; expected results
// are queued with the cycle they are due and a monitor pops them on done.
module tb_add_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  start = 3'b000;
  logic        op_sub = 1'b0;
  logic        ci = 1'b0;
  logic [63:0] a = '0;
  logic [63:0] b = '0;

  logic        ready_w [3];
  logic        done_w  [3];
  logic        co_w    [3];
  logic [63:0] s_w     [3];
  logic [1:0]  dbg_w   [3];

  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;

  // Clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  for (genvar k = 0; k < 3; k++) begin : g
    localparam int WK = (k == 0) ? 8 : ((k == 1) ? 16 : 64);
    localparam int NW = 64 / WK;

    logic [96:0] exp_q[$];
    int          busy = 0;
    logic [64:0] last = '0;

    add_seq_ctrl #(.N(64), .W(WK)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start[k]),
      .ready     (ready_w[k]),
      .op_sub    (op_sub),
      .ci        (ci),
      .a         (a),
      .b         (b),
      .s         (s_w[k]),
      .co        (co_w[k]),
      .done      (done_w[k]),
      .dbg_state (dbg_w[k])
    );

    // Reference model: busy for NW+1 cycles after an accept; result due NW+1 cycles later.
    always @(posedge clk or negedge rst) begin
      logic [64:0] full;
      if (!rst) begin
        busy = 0;
        exp_q.delete();
      end else if (busy > 0) begin
        busy--;
      end else if (start[k]) begin
        if (op_sub) full = {1'b0, a} + {1'b0, ~b} + 65'd1;
        else        full = {1'b0, a} + {1'b0, b} + {64'd0, ci};
        exp_q.push_back({32'(cyc + NW + 1), full});
        busy = NW + 1;
      end
    end

    // Monitor: ready vs model, done timing, result, and hold while idle.
    always @(negedge clk) begin
      logic        exp_done;
      logic [96:0] e;
      if (!rst) begin
        last = '0;
      end else begin
        chk($sformatf("W%0d ready", WK), 128'(ready_w[k]), 128'(busy == 0));
        exp_done = (exp_q.size() > 0) && (exp_q[0][96:65] == cyc);
        if (done_w[k] || exp_done) begin
          chk($sformatf("W%0d done", WK), 128'(done_w[k]), 128'(exp_done));
          if (exp_done) begin
            e = exp_q.pop_front();
            chk($sformatf("W%0d s", WK), 128'(s_w[k]), 128'(e[63:0]));
            chk($sformatf("W%0d co", WK), 128'(co_w[k]), 128'(e[64]));
            last = e[64:0];
          end
        end else if (busy == 0) begin
          chk($sformatf("W%0d s_hold", WK), 128'(s_w[k]), 128'(last[63:0]));
          chk($sformatf("W%0d co_hold", WK), 128'(co_w[k]), 128'(last[64]));
        end
      end
    end
  end

  function automatic bit all_idle(input logic [2:0] m);
    return (!m[0] || g[0].busy == 0) && (!m[1] || g[1].busy == 0) &&
           (!m[2] || g[2].busy == 0);
  endfunction

  task automatic wait_idle(input logic [2:0] m);
    int n = 0;
    while (!all_idle(m) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!all_idle(m)) begin
      errors++;
      $display("FAIL idle_timeout mask=%b", m);
    end
  endtask

  // Driver: one request to the masked instances, then scramble the operands.
  task automatic do_op(input logic [2:0] m, input logic [63:0] ia, input logic [63:0] ib,
                       input logic ici, input logic isub);
    @(negedge clk);
    wait_idle(m);
    a = ia;
    b = ib;
    ci = ici;
    op_sub = isub;
    start = m;
    @(negedge clk);
    start = 3'b000;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    ci = 1'($urandom);
    op_sub = 1'($urandom);
  endtask

  function automatic logic [63:0] rand_opnd();
    case ($urandom_range(0, 5))
      0:       return '1;
      1:       return '0;
      2:       return 64'($urandom_range(0, 255));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    int n;
    // Reset values.
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst ready", 128'(ready_w[i]), 128'(1'b1));
      chk("rst done", 128'(done_w[i]), 128'(1'b0));
      chk("rst s", 128'(s_w[i]), 128'(64'd0));
      chk("rst co", 128'(co_w[i]), 128'(1'b0));
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Directed arithmetic: overflow add, borrow/no-borrow sub, chunk carry.
    do_op(3'b111, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
    do_op(3'b111, 64'd5, 64'd7, 1'b0, 1'b1);
    do_op(3'b111, 64'd7, 64'd5, 1'b1, 1'b1);
    do_op(3'b111, 64'h00FF, 64'd0, 1'b1, 1'b0);
    do_op(3'b111, 64'h0000_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0);
    do_op(3'b111, 64'd0, 64'd0, 1'b0, 1'b1);

    // start held high with operands changing every cycle.
    @(negedge clk);
    wait_idle(3'b111);
    start = 3'b111;
    repeat (35) begin
      @(negedge clk);
      a = rand_opnd();
      b = rand_opnd();
      ci = 1'($urandom);
      op_sub = 1'($urandom);
    end
    start = 3'b000;

    // start pulsed only during the FIN cycle must not be accepted.
    do_op(3'b001, rand_opnd(), rand_opnd(), 1'b1, 1'b0);
    n = 0;
    while (g[0].busy != 1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    start = 3'b001;
    @(negedge clk);
    start = 3'b000;
    repeat (4) @(negedge clk);

    // Asynchronous reset in the middle of RUN.
    do_op(3'b001, rand_opnd(), rand_opnd(), 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midrun ready", 128'(ready_w[0]), 128'(1'b1));
    chk("midrun done", 128'(done_w[0]), 128'(1'b0));
    chk("midrun s", 128'(s_w[0]), 128'(64'd0));
    chk("midrun co", 128'(co_w[0]), 128'(1'b0));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (15) @(negedge clk);

    // Randomized operations across all widths.
    for (int i = 0; i < 1500; i++) begin
      logic [2:0] m;
      m = (i % 2 == 0) ? 3'b111 : 3'($urandom_range(1, 7));
      do_op(m, rand_opnd(), rand_opnd(), 1'($urandom), 1'($urandom));
    end

    @(negedge clk);
    wait_idle(3'b111);
    repeat (5) @(negedge clk);
    chk("W8 queue empty", 128'(g[0].exp_q.size()), 128'(0));
    chk("W16 queue empty", 128'(g[1].exp_q.size()), 128'(0));
    chk("W64 queue empty", 128'(g[2].exp_q.size()), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
